control_fsm: RTL and testbench
==============================

Name: control_fsm

Overview:
- Multi-cycle sequencer for the RV32I core.
- Drives the fetch/decode/execute/memory/writeback steps around the instruction decoder, ALU, register file and a single shared memory port.
- Consumes the decoder's opcode, func3, instr_valid and reg_dest fields.
- Produces one-hot-per-step strobes for the instruction register, register file, PC and memory handshake, plus halt/trap status.

Parameters:
- ACK_TIMEOUT, 0 — maximum cycles to wait for mem_ack in FETCH or MEM; 0 disables the timeout. Counter is 8 bits; legal values 0..255.

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  7  decoder opcode field of the current IR
- func3  in  3  decoder func3 field
- instr_valid  in  1  decoder legality flag
- reg_dest  in  5  decoder rd field
- branch_taken  in  1  ALU compare result, valid in EXECUTE and WRITEBACK
- mem_ack  in  1  memory port completion, one cycle per request
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write qualifier for mem_req (stores only)
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- ir_load  out  1  capture memory read data into IR
- alu_en  out  1  ALU operand/result register enable
- reg_we  out  1  register file write enable
- pc_we  out  1  PC update enable
- pc_sel  out  1  0 = PC+4, 1 = ALU target
- halted  out  1  core stopped in TRAP
- trap_cause  out  2  0 none, 1 illegal instruction, 2 SYSTEM (ecall/ebreak), 3 memory timeout

Behaviour:
- State register: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- Outputs are decoded from state plus inputs. trap_cause is a register.
- While reset is high, every output is 0. On the first edge with reset high: state = FETCH, trap_cause = 0, timeout counter = 0.
- FETCH:
  - mem_req = 1, mem_we = 0, mem_addr_sel = 0.
  - On mem_ack: ir_load = 1 in that same cycle; next state DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - No strobes.
  - instr_valid = 0 → TRAP with cause 1.
  - Otherwise → EXECUTE.
- EXECUTE:
  - alu_en = 1.
  - LOAD (0000011) or STORE (0100011) → MEM.
  - SYSTEM (1110011) → TRAP with cause 2.
  - All other opcodes → WRITEBACK.
- MEM:
  - mem_req = 1, mem_addr_sel = 1, mem_we = 1 only for STORE.
  - Stay until mem_ack; on mem_ack → WRITEBACK.
- WRITEBACK:
  - pc_we = 1. Next state FETCH.
  - pc_sel = 1 for JAL (1101111) and JALR (1100111); for BRANCH (1100011) pc_sel = branch_taken; else 0.
  - reg_we = 1 for OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR, and only when reg_dest != 0.
  - STORE, BRANCH and MEM_MISC (fence) never write.
- TRAP:
  - halted = 1; all other strobes 0.
  - Remain in TRAP until reset; trap_cause holds its value.
- Timeout (ACK_TIMEOUT > 0):
  - The counter increments each FETCH/MEM cycle without mem_ack and clears on mem_ack or on state change.
  - When the counter equals ACK_TIMEOUT and mem_ack is still 0 → TRAP with cause 3; mem_req drops next cycle.
  - A mem_ack arriving in the timeout cycle wins; no trap is raised.
- Latency with zero-wait memory:
  - ALU/branch/jump instructions: 4 cycles.
  - Load/store: 5 cycles.
  - Each wait cycle on mem_ack adds 1.
- Reset mid-instruction (any state, including during a pending mem_req) aborts immediately. No reg_we or pc_we is issued in the reset cycle.
- mem_ack outside FETCH/MEM is ignored.

Optional Feature:
- Macro: PERF_COUNTERS_EN.
- When defined, adds outputs cycle_count (32) and instret_count (32), both reset to 0.
  - cycle_count increments every non-reset cycle while not in TRAP.
  - instret_count increments on every WRITEBACK cycle.
  - Both wrap modulo 2^32.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- ADDI (opcode 0010011, rd = 5), mem_ack same cycle as request → ir_load in cycle 1; reg_we = 1 and pc_we = 1, pc_sel = 0 in cycle 4; back in FETCH in cycle 5.
- LW rd = 3, mem_ack delayed 2 cycles in both FETCH and MEM → mem_we = 0 throughout; reg_we in cycle 9; total 9 cycles.
- SW → mem_we = 1 only in MEM. BEQ with branch_taken = 1 → pc_sel = 1, reg_we = 0. ADD with rd = 0 → reg_we stays 0.
- Behaviour-level decoding cases:
  - instr_valid = 0 in DECODE → TRAP, halted = 1, trap_cause = 1, stuck for 20 cycles.
  - ECALL → trap_cause = 2.
  - Reset pulse returns to FETCH with all outputs 0.
- ACK_TIMEOUT = 4, mem_ack never arrives in FETCH → trap_cause = 3 after the 4-cycle wait. Separately, mem_ack arriving exactly in the timeout cycle → no trap, DECODE next.
- PERF_COUNTERS_EN defined, 3 ADDIs with zero-wait memory → instret_count = 3, cycle_count = 12; both freeze on entering TRAP.

Source files
------------

// File: rtl/control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : control_fsm_if
// Brief    : Decoder fields, memory handshake and step strobes around
//            control_fsm. The PERF_COUNTERS_EN macro adds the counter outputs.
// Revision : 1.0
// ============================================================================
interface control_fsm_if;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        instr_valid;
    logic [4:0]  reg_dest;
    logic        branch_taken;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_load;
    logic        alu_en;
    logic        reg_we;
    logic        pc_we;
    logic        pc_sel;
    logic        halted;
    logic [1:0]  trap_cause;
`ifdef PERF_COUNTERS_EN
    logic [31:0] cycle_count;
    logic [31:0] instret_count;
`endif

    modport master (
        input  opcode, func3, instr_valid, reg_dest, branch_taken, mem_ack,
        output mem_req, mem_we, mem_addr_sel, ir_load, alu_en, reg_we,
               pc_we, pc_sel, halted, trap_cause
`ifdef PERF_COUNTERS_EN
        , output cycle_count, instret_count
`endif
    );

    modport slave (
        output opcode, func3, instr_valid, reg_dest, branch_taken, mem_ack,
        input  mem_req, mem_we, mem_addr_sel, ir_load, alu_en, reg_we,
               pc_we, pc_sel, halted, trap_cause
`ifdef PERF_COUNTERS_EN
        , input cycle_count, instret_count
`endif
    );
endinterface
`default_nettype wire

// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : control_fsm
// Brief    : Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencer for the
//            RV32I core. Define PERF_COUNTERS_EN for cycle/instret counters.
// Revision : 1.0
// ============================================================================
module control_fsm #(
    parameter int unsigned ACK_TIMEOUT = 0
) (
    input  logic           clk,
    input  logic           reset,
    control_fsm_if.master  bus
);
    localparam logic [2:0] C_FETCH     = 3'd0;
    localparam logic [2:0] C_DECODE    = 3'd1;
    localparam logic [2:0] C_EXECUTE   = 3'd2;
    localparam logic [2:0] C_MEM       = 3'd3;
    localparam logic [2:0] C_WRITEBACK = 3'd4;
    localparam logic [2:0] C_TRAP      = 3'd5;

    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_IMM    = 7'b0010011;
    localparam logic [6:0] C_OP_OP     = 7'b0110011;
    localparam logic [6:0] C_OP_LUI    = 7'b0110111;
    localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;
    localparam logic [6:0] C_OP_JALR   = 7'b1100111;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] C_CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] C_CAUSE_SYSTEM  = 2'd2;
    localparam logic [1:0] C_CAUSE_TIMEOUT = 2'd3;

    localparam bit         C_TIMEOUT_EN = (ACK_TIMEOUT != 0);
    localparam logic [7:0] C_TIMEOUT    = 8'(ACK_TIMEOUT);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [1:0] r_cause;
    logic [1:0] w_next_cause;
    logic [7:0] r_wait;

    logic w_mem_req, w_mem_we, w_mem_addr_sel, w_ir_load, w_alu_en;
    logic w_reg_we, w_pc_we, w_pc_sel, w_halted;
    logic w_is_load, w_is_store, w_is_jump, w_is_branch, w_writes_rd;
    logic w_waiting, w_timeout;
    logic w_unused_func3;

    // func3 is carried for future CSR decoding; SYSTEM traps regardless.
    assign w_unused_func3 = ^bus.func3;

    assign w_is_load   = (bus.opcode == C_OP_LOAD);
    assign w_is_store  = (bus.opcode == C_OP_STORE);
    assign w_is_branch = (bus.opcode == C_OP_BRANCH);
    assign w_is_jump   = (bus.opcode == C_OP_JAL) || (bus.opcode == C_OP_JALR);
    assign w_writes_rd = (bus.opcode == C_OP_OP)  || (bus.opcode == C_OP_IMM)   ||
                         w_is_load                || (bus.opcode == C_OP_LUI)   ||
                         (bus.opcode == C_OP_AUIPC) || w_is_jump;

    assign w_waiting = (r_state == C_FETCH) || (r_state == C_MEM);
    assign w_timeout = C_TIMEOUT_EN && (r_wait == C_TIMEOUT) && !bus.mem_ack;

    always_comb begin
        w_next_state   = r_state;
        w_next_cause   = r_cause;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr_sel = 1'b0;
        w_ir_load      = 1'b0;
        w_alu_en       = 1'b0;
        w_reg_we       = 1'b0;
        w_pc_we        = 1'b0;
        w_pc_sel       = 1'b0;
        w_halted       = 1'b0;
        case (r_state)
            C_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ack) begin
                    w_ir_load    = 1'b1;
                    w_next_state = C_DECODE;
                end else if (w_timeout) begin
                    w_next_state = C_TRAP;
                    w_next_cause = C_CAUSE_TIMEOUT;
                end
            end
            C_DECODE: begin
                if (!bus.instr_valid) begin
                    w_next_state = C_TRAP;
                    w_next_cause = C_CAUSE_ILLEGAL;
                end else begin
                    w_next_state = C_EXECUTE;
                end
            end
            C_EXECUTE: begin
                w_alu_en = 1'b1;
                if (w_is_load || w_is_store) begin
                    w_next_state = C_MEM;
                end else if (bus.opcode == C_OP_SYSTEM) begin
                    w_next_state = C_TRAP;
                    w_next_cause = C_CAUSE_SYSTEM;
                end else begin
                    w_next_state = C_WRITEBACK;
                end
            end
            C_MEM: begin
                w_mem_req      = 1'b1;
                w_mem_addr_sel = 1'b1;
                w_mem_we       = w_is_store;
                if (bus.mem_ack) begin
                    w_next_state = C_WRITEBACK;
                end else if (w_timeout) begin
                    w_next_state = C_TRAP;
                    w_next_cause = C_CAUSE_TIMEOUT;
                end
            end
            C_WRITEBACK: begin
                w_pc_we      = 1'b1;
                w_pc_sel     = w_is_jump || (w_is_branch && bus.branch_taken);
                w_reg_we     = w_writes_rd && (bus.reg_dest != 5'd0);
                w_next_state = C_FETCH;
            end
            C_TRAP: begin
                w_halted = 1'b1;
            end
            default: begin
                w_next_state = C_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= C_FETCH;
            r_cause <= 2'd0;
            r_wait  <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_cause <= w_next_cause;
            if (!w_waiting || bus.mem_ack || (w_next_state != r_state)) begin
                r_wait <= 8'd0;
            end else begin
                r_wait <= r_wait + 8'd1;
            end
        end
    end

    // Strobes are forced low while reset is held so an aborted step never commits.
    assign bus.mem_req      = !reset && w_mem_req;
    assign bus.mem_we       = !reset && w_mem_we;
    assign bus.mem_addr_sel = !reset && w_mem_addr_sel;
    assign bus.ir_load      = !reset && w_ir_load;
    assign bus.alu_en       = !reset && w_alu_en;
    assign bus.reg_we       = !reset && w_reg_we;
    assign bus.pc_we        = !reset && w_pc_we;
    assign bus.pc_sel       = !reset && w_pc_sel;
    assign bus.halted       = !reset && w_halted;
    assign bus.trap_cause   = reset ? 2'd0 : r_cause;

`ifdef PERF_COUNTERS_EN
    logic [31:0] r_cycle_count;
    logic [31:0] r_instret_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle_count   <= 32'd0;
            r_instret_count <= 32'd0;
        end else begin
            if (r_state != C_TRAP) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
            if (r_state == C_WRITEBACK) begin
                r_instret_count <= r_instret_count + 32'd1;
            end
        end
    end

    assign bus.cycle_count   = reset ? 32'd0 : r_cycle_count;
    assign bus.instret_count = reset ? 32'd0 : r_instret_count;
`endif
endmodule
`default_nettype wire

// File: tb/tb_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_fsm
// Brief    : Directed scoreboard bench for control_fsm (ACK_TIMEOUT = 4 plus a
//            second instance with the timeout disabled).
// Revision : 1.0
// ============================================================================
module tb_control_fsm;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // {mem_req,mem_we,addr_sel}_{ir_load,alu_en,reg_we,pc_we}_{pc_sel,halted}_{cause}
    localparam logic [10:0] E_IDLE  = 11'b000_0000_00_00;
    localparam logic [10:0] E_FETCH = 11'b100_0000_00_00;
    localparam logic [10:0] E_FACK  = 11'b100_1000_00_00;
    localparam logic [10:0] E_DEC   = 11'b000_0000_00_00;
    localparam logic [10:0] E_EXE   = 11'b000_0100_00_00;
    localparam logic [10:0] E_MRD   = 11'b101_0000_00_00;
    localparam logic [10:0] E_MWR   = 11'b111_0000_00_00;
    localparam logic [10:0] E_WBN   = 11'b000_0001_00_00;
    localparam logic [10:0] E_WBR   = 11'b000_0011_00_00;
    localparam logic [10:0] E_WBJ   = 11'b000_0011_10_00;
    localparam logic [10:0] E_WBB   = 11'b000_0001_10_00;
    localparam logic [10:0] E_T1    = 11'b000_0000_01_01;
    localparam logic [10:0] E_T2    = 11'b000_0000_01_10;
    localparam logic [10:0] E_T3    = 11'b000_0000_01_11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    control_fsm_if bus ();
    control_fsm_if nt_bus ();

    control_fsm #(.ACK_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    control_fsm nt_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (nt_bus)
    );

    logic [10:0] act_main, act_nt;
    assign act_main = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_load, bus.alu_en,
                       bus.reg_we, bus.pc_we, bus.pc_sel, bus.halted, bus.trap_cause};
    assign act_nt   = {nt_bus.mem_req, nt_bus.mem_we, nt_bus.mem_addr_sel, nt_bus.ir_load,
                       nt_bus.alu_en, nt_bus.reg_we, nt_bus.pc_we, nt_bus.pc_sel,
                       nt_bus.halted, nt_bus.trap_cause};

    logic [10:0] exp_q[$];
    logic [10:0] nt_q[$];
    string       nm_q[$];
    int          tests = 0;
    int          fails = 0;

    logic [6:0]  p_op = '0;
    logic [2:0]  p_f3 = '0;
    logic [4:0]  p_rd = '0;
    logic        p_valid = 1'b1;

`ifdef PERF_COUNTERS_EN
    bit          pchk_q[$];
    logic [31:0] pcyc_q[$];
    logic [31:0] pins_q[$];
    bit          p_chk = 1'b0;
    logic [31:0] p_cyc = '0;
    logic [31:0] p_ins = '0;

    task automatic perf(input logic [31:0] ec, input logic [31:0] ei);
        p_chk = 1'b1;
        p_cyc = ec;
        p_ins = ei;
    endtask
`endif

    task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic v);
        p_op = op; p_f3 = f3; p_rd = rd; p_valid = v;
    endtask

    // One clock cycle: drive inputs after the edge, queue the expected outputs.
    task automatic cyc(input logic rst, input logic ack, input logic bt,
                       input logic [10:0] exp, input string nm);
        @(posedge clk);
        #1;
        reset            = rst;
        bus.mem_ack      = ack;
        bus.branch_taken = bt;
        bus.opcode       = p_op;
        bus.func3        = p_f3;
        bus.reg_dest     = p_rd;
        bus.instr_valid  = p_valid;
        exp_q.push_back(exp);
        nt_q.push_back(rst ? E_IDLE : E_FETCH);
        nm_q.push_back(nm);
`ifdef PERF_COUNTERS_EN
        pchk_q.push_back(p_chk);
        pcyc_q.push_back(p_cyc);
        pins_q.push_back(p_ins);
        p_chk = 1'b0;
`endif
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                             input logic bt, input logic [10:0] wb, input string nm);
        instr(op, f3, rd, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, E_FACK, "fetch");
        cyc(1'b0, 1'b0, 1'b0, E_DEC,  "decode");
        cyc(1'b0, 1'b0, bt,   E_EXE,  "execute");
        cyc(1'b0, 1'b0, bt,   wb,     nm);
    endtask

    logic [10:0] m_e, m_nt;
    string       m_n;
`ifdef PERF_COUNTERS_EN
    bit          m_pc;
    logic [31:0] m_cy, m_in;
`endif

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            m_e  = exp_q.pop_front();
            m_nt = nt_q.pop_front();
            m_n  = nm_q.pop_front();
            tests++;
            if (act_main !== m_e) begin
                fails++;
                $display("FAIL %s: outputs got %b expected %b", m_n, act_main, m_e);
            end
            tests++;
            if (act_nt !== m_nt) begin
                fails++;
                $display("FAIL %s_no_timeout: outputs got %b expected %b", m_n, act_nt, m_nt);
            end
`ifdef PERF_COUNTERS_EN
            m_pc = pchk_q.pop_front();
            m_cy = pcyc_q.pop_front();
            m_in = pins_q.pop_front();
            if (m_pc) begin
                tests++;
                if (bus.cycle_count !== m_cy || bus.instret_count !== m_in) begin
                    fails++;
                    $display("FAIL %s_perf: cycle/instret got %0d/%0d expected %0d/%0d",
                             m_n, bus.cycle_count, bus.instret_count, m_cy, m_in);
                end
            end
`endif
        end
    end

    initial begin
        reset               = 1'b1;
        bus.mem_ack         = 1'b0;
        bus.branch_taken    = 1'b0;
        bus.opcode          = '0;
        bus.func3           = '0;
        bus.reg_dest        = '0;
        bus.instr_valid     = 1'b1;
        nt_bus.mem_ack      = 1'b0;
        nt_bus.branch_taken = 1'b0;
        nt_bus.opcode       = OP_IMM;
        nt_bus.func3        = '0;
        nt_bus.reg_dest     = 5'd1;
        nt_bus.instr_valid  = 1'b1;

        cyc(1'b1, 1'b0, 1'b0, E_IDLE, "reset_a");
        cyc(1'b1, 1'b1, 1'b0, E_IDLE, "reset_ack_ignored");

        // Three zero-wait ADDIs, then an illegal instruction that traps.
        for (int k = 0; k < 3; k++) run_instr(OP_IMM, 3'd0, 5'd5, 1'b0, E_WBR, "addi_wb");
        instr(OP_IMM, 3'd0, 5'd5, 1'b0);
`ifdef PERF_COUNTERS_EN
        perf(32'd12, 32'd3);
`endif
        cyc(1'b0, 1'b1, 1'b0, E_FACK, "illegal_fetch");
`ifdef PERF_COUNTERS_EN
        perf(32'd13, 32'd3);
`endif
        cyc(1'b0, 1'b0, 1'b0, E_DEC, "illegal_decode");
        for (int k = 0; k < 20; k++) begin
`ifdef PERF_COUNTERS_EN
            perf(32'd14, 32'd3);
`endif
            cyc(1'b0, k[0], 1'b0, E_T1, "illegal_trap");
        end

        // LW with two wait cycles in both FETCH and MEM.
        instr(OP_LOAD, 3'd2, 5'd3, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, E_IDLE,  "reset_from_trap");
        cyc(1'b0, 1'b0, 1'b0, E_FETCH, "lw_fetch_wait");
        cyc(1'b0, 1'b0, 1'b0, E_FETCH, "lw_fetch_wait");
        cyc(1'b0, 1'b1, 1'b0, E_FACK,  "lw_fetch");
        cyc(1'b0, 1'b0, 1'b0, E_DEC,   "lw_decode");
        cyc(1'b0, 1'b0, 1'b0, E_EXE,   "lw_execute");
        cyc(1'b0, 1'b0, 1'b0, E_MRD,   "lw_mem_wait");
        cyc(1'b0, 1'b0, 1'b0, E_MRD,   "lw_mem_wait");
        cyc(1'b0, 1'b1, 1'b0, E_MRD,   "lw_mem");
        cyc(1'b0, 1'b0, 1'b0, E_WBR,   "lw_wb");

        // Reset during a pending fetch, then SW.
        instr(OP_STORE, 3'd2, 5'd7, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, E_FETCH, "sw_fetch_wait");
        cyc(1'b1, 1'b1, 1'b0, E_IDLE,  "reset_pending_req");
        cyc(1'b0, 1'b0, 1'b0, E_FETCH, "post_reset_fetch");
        cyc(1'b0, 1'b1, 1'b0, E_FACK,  "sw_fetch");
        cyc(1'b0, 1'b0, 1'b0, E_DEC,   "sw_decode");
        cyc(1'b0, 1'b0, 1'b0, E_EXE,   "sw_execute");
        cyc(1'b0, 1'b1, 1'b0, E_MWR,   "sw_mem");
        cyc(1'b0, 1'b0, 1'b0, E_WBN,   "sw_wb");

        run_instr(OP_BRANCH, 3'd0, 5'd9, 1'b1, E_WBB, "beq_taken_wb");
        run_instr(OP_BRANCH, 3'd1, 5'd9, 1'b0, E_WBN, "bne_not_taken_wb");

        // ADD rd=0 with stray mem_ack outside FETCH/MEM.
        instr(OP_OP, 3'd0, 5'd0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, E_FACK, "add_fetch");
        cyc(1'b0, 1'b1, 1'b0, E_DEC,  "add_decode_ack");
        cyc(1'b0, 1'b1, 1'b0, E_EXE,  "add_execute_ack");
        cyc(1'b0, 1'b1, 1'b0, E_WBN,  "add_rd0_wb");
        instr(OP_JAL, 3'd0, 5'd1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, E_FETCH, "jal_fetch_wait");
        cyc(1'b0, 1'b1, 1'b0, E_FACK,  "jal_fetch");
        cyc(1'b0, 1'b0, 1'b0, E_DEC,   "jal_decode");
        cyc(1'b0, 1'b0, 1'b0, E_EXE,   "jal_execute");
        cyc(1'b0, 1'b0, 1'b0, E_WBJ,   "jal_wb");

        run_instr(OP_JALR,  3'd0, 5'd0, 1'b0, E_WBB, "jalr_rd0_wb");
        run_instr(OP_FENCE, 3'd0, 5'd4, 1'b0, E_WBN, "fence_wb");
        run_instr(OP_LUI,   3'd0, 5'd2, 1'b0, E_WBR, "lui_wb");

        // Reset where WRITEBACK would be, then mem_ack exactly in the timeout cycle.
        instr(OP_IMM, 3'd0, 5'd5, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, E_FACK, "addi_fetch");
        cyc(1'b0, 1'b0, 1'b0, E_DEC,  "addi_decode");
        cyc(1'b0, 1'b0, 1'b0, E_EXE,  "addi_execute");
        cyc(1'b1, 1'b0, 1'b0, E_IDLE, "reset_in_writeback");
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0, E_FETCH, "ackto_fetch_wait");
        cyc(1'b0, 1'b1, 1'b0, E_FACK, "ack_at_timeout");
        cyc(1'b0, 1'b0, 1'b0, E_DEC,  "ack_at_timeout_decode");
        cyc(1'b0, 1'b0, 1'b0, E_EXE,  "ack_at_timeout_execute");
        cyc(1'b0, 1'b0, 1'b0, E_WBR,  "ack_at_timeout_wb");

        // No mem_ack at all: trap with cause 3 after the 4-cycle wait.
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b0, E_FETCH, "to_fetch_wait");
        cyc(1'b0, 1'b0, 1'b0, E_FETCH, "timeout_cycle");
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, E_T3, "timeout_trap");

        instr(OP_SYSTEM, 3'd0, 5'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, E_IDLE, "reset_from_timeout");
        cyc(1'b0, 1'b1, 1'b0, E_FACK, "ecall_fetch");
        cyc(1'b0, 1'b0, 1'b0, E_DEC,  "ecall_decode");
        cyc(1'b0, 1'b0, 1'b0, E_EXE,  "ecall_execute");
        cyc(1'b0, 1'b0, 1'b0, E_T2,   "ecall_trap");
        cyc(1'b0, 1'b1, 1'b0, E_T2,   "ecall_trap_hold");
        cyc(1'b1, 1'b0, 1'b0, E_IDLE, "reset_end");

        @(posedge clk);
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: pending %0d expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
